mgmt_irq_ctrl: RTL
==================

// Module: mgmt_irq_ctrl
// PURPOSE
//  Interrupt controller between external IRQ sources (GPIO irq pad, user-project irqs) and the mgmt CPU.
//  Synchronises sources, detects edges/levels, latches pending bits, masks and priority-encodes them.
//  Drives a single CPU irq line and a claim ID.
//  Configured and serviced over a Wishbone slave port in the housekeeping address space.
// PARAMETERS
//  NUM_IRQ      8   number of interrupt sources, 1..32
//  SYNC_STAGES  2   flops in each source synchroniser, >=2
// PORTS
//  wb_clk_i     in   1        system clock
//  wb_rst_i     in   1        synchronous reset, active-high
//  wbs_cyc_i    in   1        Wishbone cycle
//  wbs_stb_i    in   1        Wishbone strobe
//  wbs_we_i     in   1        write enable
//  wbs_sel_i    in   4        byte selects
//  wbs_adr_i    in   5        byte offset; bits [1:0] are ignored
//  wbs_dat_i    in   32       write data
//  wbs_dat_o    out  32       read data, valid with ack
//  wbs_ack_o    out  1        single-cycle ack
//  irq_src_i    in   NUM_IRQ  asynchronous interrupt sources
//  irq_o        out  1        to CPU: any enabled pending
//  irq_id_o     out  5        index of highest-priority enabled pending
// BEHAVIOUR
//  Reset (wb_rst_i=1 at a clock edge): every output is 0.
//   ENABLE=0, EDGE=all 1s, PENDING=0.
//   Synchroniser chain and edge history are cleared to 0.
//  Sync: each irq_src_i bit passes through SYNC_STAGES flops. s=sync out, h=s delayed one cycle.
//  Edge mode (EDGE[i]=1): PENDING[i] sets on s&~h and holds until cleared.
//   A source high at reset release registers one edge.
//  Level mode (EDGE[i]=0): PENDING[i] = h. W1C and claim have no effect.
//  Clearing: PENDING[i] clears on a W1C write of 1 to bit i, or on a CLAIM read returning id i.
//  Set priority: a set and a clear in the same cycle -> set wins; no edge is lost.
//  Priority: act = PENDING & ENABLE. Lowest index wins.
//  irq_o and irq_id_o are registered from act: they update 1 cycle after PENDING/ENABLE change.
//   irq_id_o = 0 when act = 0.
//  Latency: irq_src_i rise to irq_o = SYNC_STAGES+2 cycles.
//  Wishbone:
//   ack = cyc & stb & ~ack, registered: 1-cycle latency, then 1 idle cycle between acks.
//   The register side effect (write, W1C, claim clear) occurs in the ack cycle.
//   wbs_dat_o is valid only with ack, else 0.
//  Register map:
//   0x00 ENABLE   RW, byte-select honoured
//   0x04 EDGE     RW, byte-select honoured
//   0x08 PENDING  R / W1C over selected bytes
//   0x0C CLAIM    RO, returns {valid[31], 26'b0, id[4:0]} from the registered act/id
//   0x10 STATUS   RO, act
//   Others read 0; writes to others are ignored.
//   Bits >= NUM_IRQ read 0 and ignore writes.
//  Claim: a read with valid=0 has no side effect.
//   Returned id is the registered irq_id_o at ack time, even if a higher-priority source arrives that cycle.
//  Mid-access reset: ack drops, no side effect; the bus master must retry.
// TESTING
//  1. Reset, read 0x00/0x04/0x08 -> 0x0, 0xFF, 0x0 (NUM_IRQ=8); irq_o=0.
//  2. ENABLE=0x80, pulse irq_src_i[7] for 1 cycle.
//     -> irq_o=1 at cycle 4 after the pulse; CLAIM -> 0x80000007; next cycle irq_o=0, PENDING=0.
//  3. ENABLE=0x05, raise src 2 then src 0.
//     -> irq_id_o=2 then 0; CLAIM returns 0, next CLAIM returns 2, third returns 0x00000000.
//  4. EDGE=0x00, hold src 3 high with ENABLE=0x08.
//     -> irq_o stays 1; W1C 0x08 has no effect; drop src 3 -> irq_o=0 after sync latency.
//  5. Edge on src 1 in the same cycle as W1C 0x02 ack -> PENDING[1] remains 1.
//  6. Write 0x14 and read 0x18 -> ack after 1 cycle, read data 0, no register change.

Source files
------------

// File: rtl/mgmt_irq_ctrl.sv
// mgmt_irq_ctrl: interrupt controller for the management CPU.
// Synchronises external sources, latches edge/level pending bits, masks them
// with ENABLE, picks the lowest enabled pending index and exposes it to the CPU
// as a registered irq line plus claim ID. Serviced over a Wishbone slave port.
module mgmt_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [4:0]         wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  // Word addresses (byte offset >> 2)
  localparam logic [2:0] A_ENABLE  = 3'd0;
  localparam logic [2:0] A_EDGE    = 3'd1;
  localparam logic [2:0] A_PENDING = 3'd2;
  localparam logic [2:0] A_CLAIM   = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;

  // ---------------------------------------------------------------------------
  // Source synchronisation and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0]                  r_hist;
  logic [NUM_IRQ-1:0]                  w_s;
  logic [NUM_IRQ-1:0]                  w_rise;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_hist;

  // Shift each source through the synchroniser, then keep one cycle of history
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_src_i};
      r_hist <= w_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone handshake
  // ---------------------------------------------------------------------------
  logic        r_ack;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_word;
  logic [31:0] w_bmask32;
  logic [NUM_IRQ-1:0] w_wmask;
  logic [NUM_IRQ-1:0] w_wdat;

  // The ack cycle is where the access takes effect; a dropped strobe cancels it.
  assign w_acc     = r_ack & wbs_cyc_i & wbs_stb_i;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_rd      = w_acc & ~wbs_we_i;
  assign w_word    = wbs_adr_i[4:2];
  assign w_bmask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_wmask   = w_bmask32[NUM_IRQ-1:0];
  assign w_wdat    = wbs_dat_i[NUM_IRQ-1:0];

  // Registered ack; the ~r_ack term forces an idle cycle between acks
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_ack <= 1'b0;
    else          r_ack <= wbs_cyc_i & wbs_stb_i & ~r_ack;
  end

  assign wbs_ack_o = r_ack;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_edge;

  // ENABLE and EDGE writes merge only the selected bytes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_enable <= '0;
      r_edge   <= '1;
    end else begin
      if (w_wr && w_word == A_ENABLE)
        r_enable <= (r_enable & ~w_wmask) | (w_wdat & w_wmask);
      if (w_wr && w_word == A_EDGE)
        r_edge <= (r_edge & ~w_wmask) | (w_wdat & w_wmask);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_act;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_claim_clr;
  logic [NUM_IRQ-1:0] w_clr;
  logic               r_irq;
  logic [4:0]         r_id;

  assign w_act = r_pend & r_enable;
  assign w_w1c = (w_wr && w_word == A_PENDING) ? (w_wmask & w_wdat) : '0;

  // A claim clears the bit it reports, taken from the registered id
  always_comb begin
    w_claim_clr = '0;
    if (w_rd && w_word == A_CLAIM && r_irq) begin
      for (int i = 0; i < NUM_IRQ; i++)
        w_claim_clr[i] = (r_id == 5'(i));
    end
  end

  // Clears only touch edge-mode bits; level bits just follow the source
  assign w_clr = (w_w1c | w_claim_clr) & r_edge;

  // Edge bits: set beats clear so a coincident edge survives.
  // Level bits: load the synchroniser output, so PENDING equals the history flop.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_pend <= '0;
    else          r_pend <= (r_edge & ((r_pend & ~w_clr) | w_rise)) |
                            (~r_edge & w_s);
  end

  // ---------------------------------------------------------------------------
  // Priority encode and CPU outputs
  // ---------------------------------------------------------------------------
  logic [4:0] w_id;

  // Lowest index wins: scan downward so the last hit is the smallest
  always_comb begin
    w_id = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (w_act[i]) w_id = 5'(i);
  end

  // Register irq/id so the CPU and claim reads see a stable pair
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
      r_id  <= '0;
    end else begin
      r_irq <= |w_act;
      r_id  <= w_id;
    end
  end

  assign irq_o    = r_irq;
  assign irq_id_o = r_id;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  // Zero-extend NUM_IRQ-wide registers; unmapped words read zero
  always_comb begin
    w_rdata = '0;
    case (w_word)
      A_ENABLE:  w_rdata[NUM_IRQ-1:0] = r_enable;
      A_EDGE:    w_rdata[NUM_IRQ-1:0] = r_edge;
      A_PENDING: w_rdata[NUM_IRQ-1:0] = r_pend;
      A_CLAIM:   w_rdata = {r_irq, 26'b0, r_id};
      A_STATUS:  w_rdata[NUM_IRQ-1:0] = w_act;
      default:   w_rdata = '0;
    endcase
  end

  assign wbs_dat_o = (r_ack && !wbs_we_i) ? w_rdata : 32'h0;

  // Address low bits and write bits beyond NUM_IRQ are don't-care
  logic w_unused;
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_bmask32};

endmodule
